// File: rtl/tile_accum_scheduler_pkg.sv
// Shared definitions for the tile accumulation scheduler and the layer controller:
// FSM state encoding, default latencies and lane-slice widths.
package tile_accum_scheduler_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ISSUE = 3'd1;
   localparam state_t ST_WAIT  = 3'd2;
   localparam state_t ST_SCALE = 3'd3;
   localparam state_t ST_OUT   = 3'd4;

   localparam int ADDER_LAT_DEF     = 4;
   localparam int FEATURE_WIDTH_DEF = 16;
   localparam int SCALER_WIDTH_DEF  = 16;

   // Width of one scaled output lane: full unsigned product of accumulator and scaler.
   function automatic int lane_out_width(input int feature_width, input int scaler_width);
      return feature_width + scaler_width;
   endfunction

endpackage

// File: rtl/tile_accum_scheduler_lane.sv
// One lane of the scheduler datapath: wrapping tile accumulator plus the
// registered full-width scaled result presented downstream.
module tile_lane_accum
   import tile_accum_scheduler_pkg::*;
#(
   parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
   parameter int SCALER_WIDTH  = SCALER_WIDTH_DEF
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  i_clear,
   input  logic                                                  i_add_en,
   input  logic [FEATURE_WIDTH-1:0]                              i_lane_sum,
   input  logic                                                  i_scale_en,
   input  logic [SCALER_WIDTH-1:0]                               i_scaler,
   output logic [lane_out_width(FEATURE_WIDTH, SCALER_WIDTH)-1:0] o_scaled
);

   localparam int PW = lane_out_width(FEATURE_WIDTH, SCALER_WIDTH);

   logic [FEATURE_WIDTH-1:0] r_acc;
   logic [PW-1:0]            r_scaled;

   // NOTE: state uses non-blocking (<=) so every register samples pre-edge values;
   // datapath registers are reset too because out_data is observable right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_scaled <= '0;
      end else begin
         if (i_clear)
            r_acc <= '0;
         else if (i_add_en)
            r_acc <= r_acc + i_lane_sum;
         if (i_scale_en)
            r_scaled <= PW'(r_acc) * PW'(i_scaler);
      end
   end

   assign o_scaled = r_scaled;

endmodule

// File: rtl/tile_accum_scheduler.sv
// Sequences the adder tree across num_tiles input-channel tiles, accumulates the
// lane sums, scales them and hands the result downstream with valid/ready.
module tile_accum_scheduler
   import tile_accum_scheduler_pkg::*;
#(
   parameter int TN             = 4,
   parameter int FEATURE_WIDTH  = FEATURE_WIDTH_DEF,
   parameter int SCALER_WIDTH   = SCALER_WIDTH_DEF,
   parameter int ADDER_LAT      = ADDER_LAT_DEF,
   parameter int TILE_CNT_WIDTH = 8
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   input  logic [TILE_CNT_WIDTH-1:0]                    num_tiles,
   input  logic [SCALER_WIDTH-1:0]                      scaler,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   output logic                                         adder_enable,
   input  logic                                         adder_done,
   input  logic [TN*FEATURE_WIDTH-1:0]                  kernel_sum_tn,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [TN*(FEATURE_WIDTH+SCALER_WIDTH)-1:0]   out_data,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         err
);

   localparam int                LANE_W     = lane_out_width(FEATURE_WIDTH, SCALER_WIDTH);
   localparam int                WDOG_W     = $clog2(ADDER_LAT + 1) + 1;
   // wdog is cleared at the enable and first reads 0 in WAIT, so hitting ADDER_LAT
   // here lands the timeout ADDER_LAT+2 cycles after the enable.
   localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(ADDER_LAT);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [TILE_CNT_WIDTH-1:0] r_num_tiles;
   logic [SCALER_WIDTH-1:0]   r_scaler;
   logic [TILE_CNT_WIDTH-1:0] r_tile_cnt;
   logic [WDOG_W-1:0]         r_wdog;
   logic                      r_done;
   logic                      r_err;

   logic w_start_acc;
   logic w_start_job;
   logic w_issue;
   logic w_add;
   logic w_last;
   logic w_timeout;
   logic w_scale;
   logic w_handshake;

   assign w_start_acc = (r_state == ST_IDLE) && start;
   assign w_start_job = w_start_acc && (num_tiles != '0);
   assign w_issue     = (r_state == ST_ISSUE) && in_valid;
   assign w_add       = (r_state == ST_WAIT) && adder_done;
   assign w_last      = (r_tile_cnt == r_num_tiles - TILE_CNT_WIDTH'(1));
   assign w_timeout   = (r_state == ST_WAIT) && !adder_done && (r_wdog == WDOG_LIMIT);
   assign w_scale     = (r_state == ST_SCALE);
   assign w_handshake = (r_state == ST_OUT) && out_ready;

   // NOTE: default assignment first so no path through the case leaves w_state_nxt unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_job) w_state_nxt = ST_ISSUE;
         ST_ISSUE: if (in_valid) w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (adder_done)
               w_state_nxt = w_last ? ST_SCALE : ST_ISSUE;
            else if (w_timeout)
               w_state_nxt = ST_IDLE;
         end
         ST_SCALE: w_state_nxt = ST_OUT;
         ST_OUT:   if (out_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_num_tiles <= '0;
         r_scaler    <= '0;
         r_tile_cnt  <= '0;
         r_wdog      <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_start_acc && (num_tiles == '0)) || w_timeout || w_handshake;

         if (w_start_acc)
            r_err <= 1'b0;
         else if (w_timeout)
            r_err <= 1'b1;

         if (w_start_job) begin
            r_num_tiles <= num_tiles;
            r_scaler    <= scaler;
            r_tile_cnt  <= '0;
         end else if (w_add) begin
            r_tile_cnt <= r_tile_cnt + TILE_CNT_WIDTH'(1);
         end

         if (w_issue)
            r_wdog <= '0;
         else if (r_state == ST_WAIT)
            r_wdog <= r_wdog + WDOG_W'(1);
      end
   end

   for (genvar g = 0; g < TN; g++) begin : g_lane
      tile_lane_accum #(
         .FEATURE_WIDTH(FEATURE_WIDTH),
         .SCALER_WIDTH (SCALER_WIDTH)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .i_clear   (w_start_job),
         .i_add_en  (w_add),
         .i_lane_sum(kernel_sum_tn[g*FEATURE_WIDTH +: FEATURE_WIDTH]),
         .i_scale_en(w_scale),
         .i_scaler  (r_scaler),
         .o_scaled  (out_data[g*LANE_W +: LANE_W])
      );
   end

   assign in_ready     = (r_state == ST_ISSUE);
   assign adder_enable = w_issue;
   assign out_valid    = (r_state == ST_OUT);
   assign busy         = (r_state != ST_IDLE);
   assign done         = r_done;
   assign err          = r_err;

endmodule

// File: doc/tile_accum_scheduler.md
Name: tile_accum_scheduler

Overview:
- Sequences the Tn-kernel adder tree across NUM_TILES input-channel tiles for one output pixel group.
- Issues one enable per tile and waits for the tree's done strobe. Accumulates the Tn lane sums, then applies a per-layer scaler and presents the scaled result downstream with valid/ready.
- Sits between the ternary-product feed (upstream) and the output write-back buffer (downstream).

Parameters:
- TN, 4, number of lanes (kernels) processed in parallel.
- FEATURE_WIDTH, 16, lane sum and accumulator width.
- SCALER_WIDTH, 16, scaler width.
- ADDER_LAT, 4, cycles from adder_enable to adder_done.
- TILE_CNT_WIDTH, 8, width of the tile count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- num_tiles  in  TILE_CNT_WIDTH  tiles per job; latched at start
- scaler  in  SCALER_WIDTH  unsigned scaler; latched at start
- in_valid  in  1  upstream tile data present on the adder-tree inputs
- in_ready  out  1  scheduler accepts a tile this cycle
- adder_enable  out  1  enable to the adder tree; equals in_valid & in_ready
- adder_done  in  1  adder tree result-valid strobe
- kernel_sum_tn  in  TN*FEATURE_WIDTH  lane sums; lane i at [(i+1)*FEATURE_WIDTH-1 : i*FEATURE_WIDTH]
- out_valid  out  1  scaled result valid
- out_ready  in  1  downstream accepts
- out_data  out  TN*(FEATURE_WIDTH+SCALER_WIDTH)  scaled lanes, same lane packing as kernel_sum_tn
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky timeout flag; cleared on accepted start

Behaviour:
- Reset: state IDLE; accumulators, tile_cnt, wdog and out_data cleared. in_ready, adder_enable, out_valid, busy, done and err are all 0.
- IDLE:
  - start with num_tiles!=0: latch num_tiles and scaler, clear accumulators and tile_cnt, clear err, go to ISSUE.
  - start with num_tiles==0: done=1 next cycle, err cleared, stay IDLE, no adder_enable.
- ISSUE:
  - in_ready=1.
  - On in_valid: adder_enable=1 (combinational, same cycle), clear wdog, go to WAIT.
  - in_valid low: hold with no timeout.
- WAIT:
  - in_ready=0; wdog increments each cycle.
  - On adder_done: acc[i] <= acc[i] + lane i, modulo 2^FEATURE_WIDTH (wrap, no saturation); tile_cnt++.
  - Then go to SCALE if tile_cnt == num_tiles-1, else to ISSUE.
  - If wdog reaches ADDER_LAT+2 without adder_done: err=1, done pulse, go to IDLE, out_valid never asserted.
- SCALE (1 cycle): out_data lane i <= acc[i] * scaler_latched, unsigned, full width (FEATURE_WIDTH+SCALER_WIDTH); go to OUT.
- OUT:
  - out_valid=1; out_data held stable until out_ready.
  - On handshake: go to IDLE, done=1 in the following cycle.
- adder_done outside WAIT is ignored. start outside IDLE is ignored.
- Timing with continuous in_valid and out_ready:
  - ISSUE→ISSUE per tile takes ADDER_LAT+1 cycles.
  - Start accepted in cycle s gives first ISSUE at s+1 and out_valid at s+1+N*(ADDER_LAT+1)+1. The done pulse follows 1 cycle after the handshake.
- Reset mid-operation: all outputs return to reset values on the next cycle. A partial job is discarded.

Decomposition:
- Shared package: FSM state encoding (IDLE, ISSUE, WAIT, SCALE, OUT), the ADDER_LAT default and the lane-slice width constants. The same package is reused by the layer controller.
- One natural sub-module: tile_lane_accum, one per lane via generate. It holds the wrapped accumulator and the scaled output register and has clear, add_en and scale_en inputs.

Test Plan:
- Two-tile job: TN=4, num_tiles=2, scaler=3, lane sums {1,2,3,4} then {10,20,30,40} → out_data {33,66,99,132}; out_valid at cycle s+12, done one cycle after the handshake, exactly 2 adder_enable pulses.
- Backpressure: hold out_ready=0 for 5 cycles in OUT → out_valid stays 1, out_data unchanged; done only after out_ready=1.
- Wrap: num_tiles=2, lane0 sums 0xFFFF then 0x0002, scaler=2 → lane0 out = 2.
- Zero tiles: start with num_tiles=0 → done pulse next cycle, busy stays 0, no adder_enable, no out_valid.
- Stalls and spurious inputs:
  - in_valid low for 3 cycles in ISSUE → no enable and no timeout.
  - start during WAIT → ignored.
  - adder_done pulsed in ISSUE → accumulators unchanged.
- Fault and reset:
  - Suppress adder_done → err=1 and done pulse 6 cycles after the enable, return to IDLE.
  - Next start → err cleared.
  - rst asserted in WAIT → all outputs 0 the next cycle.
